// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage with same-cycle WB-to-ID bypass.
// Optional sub-word load extraction is enabled by defining WB_LOAD_EXT_EN.
module mem_wb_writeback #(
  parameter int COUNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               MemValid,
  input  logic               MemRegWrite,
  input  logic               MemMemToReg,
  input  logic [4:0]         MemWriteRegister,
  input  logic [31:0]        MemALUResult,
  input  logic [31:0]        MemReadData,
`ifdef WB_LOAD_EXT_EN
  input  logic [1:0]         MemLoadSize,
  input  logic [0:0]         MemLoadSigned,
`endif
  input  logic [4:0]         ReadRegister1,
  input  logic [4:0]         ReadRegister2,
  output logic               RegWrite,
  output logic [4:0]         WriteRegister,
  output logic [31:0]        WriteData,
  output logic               Fwd1Hit,
  output logic               Fwd2Hit,
  output logic [31:0]        FwdData,
  output logic [COUNT_W-1:0] RetireCount
);

  logic               r_regwrite;
  logic [4:0]         r_wreg;
  logic [31:0]        r_wdata;
  logic [COUNT_W-1:0] r_cnt;

  logic        w_regwrite;
  logic [31:0] w_load;
  logic [31:0] w_wdata;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane select; size 2'b11 falls through to a full word.
  always_comb begin
    w_byte = MemReadData[7:0];
    case (MemALUResult[1:0])
      2'b00:   w_byte = MemReadData[7:0];
      2'b01:   w_byte = MemReadData[15:8];
      2'b10:   w_byte = MemReadData[23:16];
      default: w_byte = MemReadData[31:24];
    endcase
    w_half = MemALUResult[1] ? MemReadData[31:16] : MemReadData[15:0];
    case (MemLoadSize)
      2'b01:   w_load = {{16{MemLoadSigned[0] & w_half[15]}}, w_half};
      2'b10:   w_load = {{24{MemLoadSigned[0] & w_byte[7]}}, w_byte};
      default: w_load = MemReadData;
    endcase
  end
`else
  assign w_load = MemReadData;
`endif

  // A write to $0 or from an invalid slot is captured as a bubble.
  assign w_regwrite = MemValid & MemRegWrite & (MemWriteRegister != 5'd0);
  assign w_wdata    = MemMemToReg ? w_load : MemALUResult;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_regwrite <= 1'b0;
      r_wreg     <= 5'd0;
      r_wdata    <= 32'd0;
      r_cnt      <= '0;
    end else if (Flush) begin
      r_regwrite <= 1'b0;
      r_wreg     <= 5'd0;
      r_wdata    <= 32'd0;
    end else if (!Stall) begin
      r_regwrite <= w_regwrite;
      r_wreg     <= MemWriteRegister;
      r_wdata    <= w_wdata;
      if (w_regwrite) r_cnt <= r_cnt + COUNT_W'(1);
    end
  end

  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;
  assign RetireCount   = r_cnt;

  // r_regwrite is never set for $0, but the read-side guard keeps $0 unforwardable.
  assign Fwd1Hit = r_regwrite & (r_wreg == ReadRegister1) & (ReadRegister1 != 5'd0);
  assign Fwd2Hit = r_regwrite & (r_wreg == ReadRegister2) & (ReadRegister2 != 5'd0);
  assign FwdData = r_wdata;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed, table-driven bench for mem_wb_writeback plus multi-cycle sequences.
// A second instance with COUNT_W=4 checks counter wrap.
module tb_mem_wb_writeback;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, MemValid, MemRegWrite, MemMemToReg;
  logic [4:0]  MemWriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0] MemALUResult, MemReadData;
  logic [1:0]  MemLoadSize;
  logic [0:0]  MemLoadSigned;
  logic        RegWrite, Fwd1Hit, Fwd2Hit;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData, FwdData;
  logic [15:0] RetireCount;
  logic        s_RegWrite, s_Fwd1Hit, s_Fwd2Hit;
  logic [4:0]  s_WriteRegister;
  logic [31:0] s_WriteData, s_FwdData;
  logic [3:0]  s_RetireCount;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 Clk = ~Clk;

  mem_wb_writeback dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemMemToReg(MemMemToReg),
    .MemWriteRegister(MemWriteRegister), .MemALUResult(MemALUResult),
    .MemReadData(MemReadData),
`ifdef WB_LOAD_EXT_EN
    .MemLoadSize(MemLoadSize), .MemLoadSigned(MemLoadSigned),
`endif
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Fwd1Hit(Fwd1Hit), .Fwd2Hit(Fwd2Hit), .FwdData(FwdData),
    .RetireCount(RetireCount)
  );

  mem_wb_writeback #(.COUNT_W(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemMemToReg(MemMemToReg),
    .MemWriteRegister(MemWriteRegister), .MemALUResult(MemALUResult),
    .MemReadData(MemReadData),
`ifdef WB_LOAD_EXT_EN
    .MemLoadSize(MemLoadSize), .MemLoadSigned(MemLoadSigned),
`endif
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RegWrite(s_RegWrite), .WriteRegister(s_WriteRegister), .WriteData(s_WriteData),
    .Fwd1Hit(s_Fwd1Hit), .Fwd2Hit(s_Fwd2Hit), .FwdData(s_FwdData),
    .RetireCount(s_RetireCount)
  );

  typedef struct {
    logic        valid, rw, m2r;
    logic [4:0]  wreg;
    logic [31:0] alu, rd;
    logic [4:0]  rr1, rr2;
    logic        e_rw;
    logic [4:0]  e_wreg;
    logic [31:0] e_wd;
    logic        e_f1, e_f2;
    int          e_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd);
    MemValid = v; MemRegWrite = rw; MemMemToReg = m2r;
    MemWriteRegister = wr; MemALUResult = alu; MemReadData = rd;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic check_out(input string tag, input logic rw, input logic [4:0] wr,
                           input logic [31:0] wd, input int cnt);
    check({tag, ".RegWrite"}, 32'(RegWrite), 32'(rw));
    check({tag, ".WriteRegister"}, 32'(WriteRegister), 32'(wr));
    check({tag, ".WriteData"}, WriteData, wd);
    check({tag, ".RetireCount"}, 32'(RetireCount), 32'(cnt));
  endtask

  initial begin
    // valid rw m2r wreg alu rd rr1 rr2 | e_rw e_wreg e_wd e_f1 e_f2 e_cnt
    vecs[0] = '{1, 1, 0, 5'd9,  32'h0000_1234, 32'h0,         5'd9, 5'd10, 1, 5'd9,  32'h0000_1234, 1, 0, 1};
    vecs[1] = '{1, 1, 0, 5'd0,  32'hFFFF_FFFF, 32'h0,         5'd0, 5'd0,  0, 5'd0,  32'hFFFF_FFFF, 0, 0, 1};
    vecs[2] = '{1, 1, 1, 5'd5,  32'h0,         32'hDEAD_BEEF, 5'd3, 5'd5,  1, 5'd5,  32'hDEAD_BEEF, 0, 1, 2};
    vecs[3] = '{0, 1, 0, 5'd7,  32'h77,        32'h0,         5'd7, 5'd7,  0, 5'd7,  32'h77,        0, 0, 2};
    vecs[4] = '{1, 0, 0, 5'd8,  32'h88,        32'h0,         5'd8, 5'd0,  0, 5'd8,  32'h88,        0, 0, 2};
    vecs[5] = '{1, 1, 0, 5'd31, 32'h8000_0000, 32'h0,         5'd31, 5'd31, 1, 5'd31, 32'h8000_0000, 1, 1, 3};

    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    MemLoadSize = 2'b00; MemLoadSigned = 1'b0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    #12;
    check_out("reset", 0, 5'd0, 32'h0, 0);
    check("reset.Fwd1Hit", 32'(Fwd1Hit), 32'h0);
    @(negedge Clk); Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].wreg, vecs[i].alu, vecs[i].rd);
      ReadRegister1 = vecs[i].rr1; ReadRegister2 = vecs[i].rr2;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wreg, vecs[i].e_wd, vecs[i].e_cnt);
      check($sformatf("vec%0d.Fwd1Hit", i), 32'(Fwd1Hit), 32'(vecs[i].e_f1));
      check($sformatf("vec%0d.Fwd2Hit", i), 32'(Fwd2Hit), 32'(vecs[i].e_f2));
      check($sformatf("vec%0d.FwdData", i), FwdData, vecs[i].e_wd);
    end
    exp_cnt = 3;

    // Stall holds the captured write while MEM inputs move on.
    drive(1, 1, 0, 5'd12, 32'hAA, 32'h0);
    tick(); exp_cnt++;
    check_out("cap12", 1, 5'd12, 32'hAA, exp_cnt);
    drive(1, 1, 0, 5'd13, 32'hBB, 32'h0);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), 1, 5'd12, 32'hAA, exp_cnt);
    end
    Flush = 1'b1;
    tick();
    check_out("stallflush", 0, 5'd0, 32'h0, exp_cnt);
    Stall = 1'b0;
    drive(1, 1, 0, 5'd14, 32'hCC, 32'h0);
    tick();
    check_out("flush", 0, 5'd0, 32'h0, exp_cnt);
    Flush = 1'b0;

    // Mid-cycle async reset with RegWrite=1 and count 5.
    drive(1, 1, 0, 5'd15, 32'h55, 32'h0);
    tick(); exp_cnt++;
    check_out("pre_reset", 1, 5'd15, 32'h55, 5);
    @(negedge Clk); Reset = 1'b1; #1;
    check_out("async_reset", 0, 5'd0, 32'h0, 0);
    @(negedge Clk); Reset = 1'b0;

`ifdef WB_LOAD_EXT_EN
    MemLoadSize = 2'b10; MemLoadSigned = 1'b1;
    drive(1, 1, 1, 5'd4, 32'h0000_0002, 32'hDEAD_BEEF);
    tick();
    check("ext.byte_signed", WriteData, 32'hFFFF_FFAD);
    MemLoadSize = 2'b01; MemLoadSigned = 1'b0;
    drive(1, 1, 1, 5'd4, 32'h0000_0000, 32'hDEAD_BEEF);
    tick();
    check("ext.half_unsigned", WriteData, 32'h0000_BEEF);
    MemLoadSize = 2'b00;
    @(negedge Clk); Reset = 1'b1; #1;
    @(negedge Clk); Reset = 1'b0;
`endif

    // 17 captured writes: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 5'(1 + (i % 31)), 32'(i), 32'h0);
      tick();
    end
    check("wrap.small", 32'(s_RetireCount), 32'd1);
    check("wrap.big", 32'(RetireCount), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
